// File: rtl/hamming_score_tracker.sv
// Scores each 16-word hash frame by its Hamming distance to the target. Keeps the best
// (lowest) score and the nonce that produced it.
`timescale 1ns/1ps
module hamming_score_tracker #(
  parameter int unsigned WORDS   = 16,
  parameter int unsigned WORD_W  = 64,
  parameter int unsigned NONCE_W = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               hash_valid_i,
  output logic               hash_ready_o,
  input  logic [WORD_W-1:0]  hash_word_i,
  input  logic               hash_last_i,
  input  logic [NONCE_W-1:0] nonce_i,
  output logic [3:0]         word_idx_o,
  input  logic [WORD_W-1:0]  target_word_i,
  input  logic               clear_best_i,
  output logic [63:0]        bit_counter_register_o,
  output logic [63:0]        compare_register_o,
  output logic [NONCE_W-1:0] best_nonce_o,
  output logic               result_valid_o,
  output logic               new_best_o,
  output logic               protocol_err_o
);

  localparam int unsigned PopW = $clog2(WORD_W + 1);
  localparam int unsigned AccW = $clog2(WORDS * WORD_W + 1);
  localparam logic [3:0] LastIdx = 4'(WORDS - 1);

  typedef enum logic [0:0] {StAccum, StCompare} state_e;

  state_e             state_q, state_d;
  logic [3:0]         idx_q;
  logic [AccW-1:0]    acc_q;
  logic [NONCE_W-1:0] nonce_q;
  logic [NONCE_W-1:0] best_nonce_q;
  logic [63:0]        best_q;
  logic               rv_q, nb_q, err_q;

  logic [WORD_W-1:0]  diff;
  logic [PopW-1:0]    pop;
  logic [63:0]        score_ext;
  logic               accept, at_last, frame_end;

  assign diff      = hash_word_i ^ target_word_i;
  assign accept    = hash_valid_i && hash_ready_o;
  assign at_last   = (idx_q == LastIdx);
  assign frame_end = accept && (hash_last_i || at_last);
  assign score_ext = 64'(acc_q);

  always_comb begin
    pop = '0;
    for (int i = 0; i < int'(WORD_W); i++) begin
      pop = pop + PopW'(diff[i]);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StAccum:   if (frame_end) state_d = StCompare;
      StCompare: state_d = StAccum;
      default:   state_d = StAccum;
    endcase
  end

  assign hash_ready_o = (state_q == StAccum);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StAccum;
      idx_q        <= '0;
      acc_q        <= '0;
      nonce_q      <= '0;
      best_nonce_q <= '0;
      best_q       <= '1;
      rv_q         <= 1'b0;
      nb_q         <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      rv_q    <= 1'b0;
      nb_q    <= 1'b0;
      if (accept) begin
        // Word 0 restarts the score, so the previous result stays visible until then.
        if (idx_q == '0) begin
          acc_q   <= AccW'(pop);
          nonce_q <= nonce_i;
        end else begin
          acc_q <= acc_q + AccW'(pop);
        end
        idx_q <= frame_end ? 4'd0 : idx_q + 4'd1;
        if (hash_last_i != at_last) err_q <= 1'b1;
      end
      if (state_q == StCompare) begin
        rv_q <= 1'b1;
        if (!clear_best_i && (score_ext < best_q)) begin
          best_q       <= score_ext;
          best_nonce_q <= nonce_q;
          nb_q         <= 1'b1;
        end
      end
      // Placed last so a clear coinciding with the compare takes priority.
      if (clear_best_i) begin
        best_q       <= '1;
        best_nonce_q <= '0;
      end
    end
  end

  assign word_idx_o             = idx_q;
  assign bit_counter_register_o = score_ext;
  assign compare_register_o     = best_q;
  assign best_nonce_o           = best_nonce_q;
  assign result_valid_o         = rv_q;
  assign new_best_o             = nb_q;
  assign protocol_err_o         = err_q;

endmodule
